// File: rtl/issue_scoreboard_if.sv
// ============================================================================
// issue_scoreboard_if
// Decode-pair, writeback-release and issue/stall signals between the dual-slot
// decoder, the writeback stage and the issue scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface issue_scoreboard_if #(
  parameter int NREG = 32,
  parameter int NWB  = 2
);
  // Slot 0 decode register contents (raw valid, not stall-gated)
  logic             inst0_valid_i;
  logic             inst0_rs1_valid_i;
  logic             inst0_rs2_valid_i;
  logic             inst0_rs3_valid_i;
  logic [4:0]       inst0_rs1_i;
  logic [4:0]       inst0_rs2_i;
  logic [1:0]       inst0_rd_type_i;
  logic [4:0]       inst0_rd_i;
  // Slot 1 decode register contents
  logic             inst1_valid_i;
  logic             inst1_rs1_valid_i;
  logic             inst1_rs2_valid_i;
  logic             inst1_rs3_valid_i;
  logic [4:0]       inst1_rs1_i;
  logic [4:0]       inst1_rs2_i;
  logic [1:0]       inst1_rd_type_i;
  logic [4:0]       inst1_rd_i;
  // Writeback release ports, port k at wb_rd_i[5k+4:5k]
  logic [NWB-1:0]   wb_valid_i;
  logic [5*NWB-1:0] wb_rd_i;
  // Scoreboard results
  logic             stall_decoder_o;
  logic             issue0_o;
  logic             issue1_o;
  logic [NREG-1:0]  busy_o;

  // Decoder / writeback side
  modport master (
    output inst0_valid_i, inst0_rs1_valid_i, inst0_rs2_valid_i, inst0_rs3_valid_i,
           inst0_rs1_i, inst0_rs2_i, inst0_rd_type_i, inst0_rd_i,
           inst1_valid_i, inst1_rs1_valid_i, inst1_rs2_valid_i, inst1_rs3_valid_i,
           inst1_rs1_i, inst1_rs2_i, inst1_rd_type_i, inst1_rd_i,
           wb_valid_i, wb_rd_i,
    input  stall_decoder_o, issue0_o, issue1_o, busy_o
  );

  // Scoreboard side
  modport slave (
    input  inst0_valid_i, inst0_rs1_valid_i, inst0_rs2_valid_i, inst0_rs3_valid_i,
           inst0_rs1_i, inst0_rs2_i, inst0_rd_type_i, inst0_rd_i,
           inst1_valid_i, inst1_rs1_valid_i, inst1_rs2_valid_i, inst1_rs3_valid_i,
           inst1_rs1_i, inst1_rs2_i, inst1_rd_type_i, inst1_rd_i,
           wb_valid_i, wb_rd_i,
    output stall_decoder_o, issue0_o, issue1_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/issue_scoreboard.sv
// ============================================================================
// issue_scoreboard
// Tracks pending GPR writes, stalls the decoder on RAW/WAW/serialization
// hazards and splits a hazardous decoded pair into two single issues.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_scoreboard #(
  parameter int NREG = 32,   // tracked GPRs, at most 32 (5-bit addresses)
  parameter int NWB  = 2
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         flush_i,
  issue_scoreboard_if.slave sb
);

  typedef enum logic [0:0] {IDLE = 1'b0, SPLIT = 1'b1} state_e;

  // SPLIT doubles as the split_done flag: slot 0 already issued, slot 1 pending
  state_e          state_q, state_d;
  logic [NREG-1:0] busy_q, busy_d;

  logic [31:0] w_busy;
  logic        w_hz0, w_hz1, w_wr0, w_wr1, w_ser1, w_conflict;
  logic        w_stall, w_iss0, w_iss1;

  // A valid, non-x0 register address that is currently pending a write
  function automatic logic reg_hit(input logic v, input logic [4:0] a,
                                   input logic [31:0] b);
    return v && (a != 5'd0) && b[a];
  endfunction

  // RAW on sources, WAW on a GPR destination, or serializing op behind any busy bit
  function automatic logic slot_hazard(input logic r1v, input logic r2v,
                                       input logic r3v, input logic [4:0] r1,
                                       input logic [4:0] r2, input logic [1:0] rdt,
                                       input logic [4:0] rd, input logic [31:0] b);
    logic ser;
    ser = rdt[1] | r3v;
    return reg_hit(r1v, r1, b) | reg_hit(r2v, r2, b) |
           reg_hit(rdt == 2'b01, rd, b) | (ser && (b != 32'd0));
  endfunction

  // Zero-extend busy so 5-bit addresses always index in range
  always_comb begin
    w_busy = '0;
    w_busy[NREG-1:0] = busy_q;
  end

  // Per-slot hazards and the intra-pair dependency check
  always_comb begin
    w_hz0 = slot_hazard(sb.inst0_rs1_valid_i, sb.inst0_rs2_valid_i, sb.inst0_rs3_valid_i,
                        sb.inst0_rs1_i, sb.inst0_rs2_i, sb.inst0_rd_type_i,
                        sb.inst0_rd_i, w_busy);
    w_hz1 = slot_hazard(sb.inst1_rs1_valid_i, sb.inst1_rs2_valid_i, sb.inst1_rs3_valid_i,
                        sb.inst1_rs1_i, sb.inst1_rs2_i, sb.inst1_rd_type_i,
                        sb.inst1_rd_i, w_busy);
    w_wr0  = (sb.inst0_rd_type_i == 2'b01) && (sb.inst0_rd_i != 5'd0);
    w_wr1  = (sb.inst1_rd_type_i == 2'b01) && (sb.inst1_rd_i != 5'd0);
    w_ser1 = sb.inst1_rd_type_i[1] | sb.inst1_rs3_valid_i;
    w_conflict = w_ser1 ||
                 (w_wr0 && ((sb.inst1_rs1_valid_i && (sb.inst1_rs1_i == sb.inst0_rd_i)) ||
                            (sb.inst1_rs2_valid_i && (sb.inst1_rs2_i == sb.inst0_rd_i)) ||
                            ((sb.inst1_rd_type_i == 2'b01) &&
                             (sb.inst1_rd_i == sb.inst0_rd_i))));
  end

  // Issue/split FSM: next state and issue/stall decisions
  always_comb begin
    state_d = state_q;
    w_stall = 1'b0;
    w_iss0  = 1'b0;
    w_iss1  = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sb.inst0_valid_i) begin
            if (w_hz0) begin
              w_stall = 1'b1;
            end else if (!sb.inst1_valid_i || (!w_hz1 && !w_conflict)) begin
              w_iss0 = 1'b1;
              w_iss1 = sb.inst1_valid_i;
            end else begin
              w_iss0  = 1'b1;
              w_stall = 1'b1;
              state_d = SPLIT;
            end
          end else if (sb.inst1_valid_i) begin
            // Lone slot 1: nothing older in the pair, so no conflict term
            if (w_hz1) w_stall = 1'b1;
            else       w_iss1  = 1'b1;
          end
        end
        SPLIT: begin
          // Slot 0 left last cycle; its destination is already in busy_q
          if (sb.inst1_valid_i && w_hz1) begin
            w_stall = 1'b1;
          end else begin
            w_iss1  = sb.inst1_valid_i;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Busy next state: writeback clears first, then issue sets so a set wins
  always_comb begin
    logic [31:0] nxt;
    nxt = w_busy;
    for (int k = 0; k < NWB; k++) begin
      if (sb.wb_valid_i[k]) nxt[sb.wb_rd_i[5*k +: 5]] = 1'b0;
    end
    if (w_iss0 && w_wr0) nxt[sb.inst0_rd_i] = 1'b1;
    if (w_iss1 && w_wr1) nxt[sb.inst1_rd_i] = 1'b1;
    nxt[0] = 1'b0;
    if (flush_i) nxt = '0;
    busy_d = nxt[NREG-1:0];
  end

  // State and busy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  assign sb.stall_decoder_o = w_stall;
  assign sb.issue0_o        = w_iss0;
  assign sb.issue1_o        = w_iss1;
  assign sb.busy_o          = busy_q;

endmodule

`default_nettype wire
